mmio_button_hub: RTL and testbench

//  Parametrised memory-mapped input/output hub between the processor data port and board I/O.

---
 rtl/mmio_button_hub.sv | 136 +++++++++++++
 tb/tb_mmio_button_hub.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_button_hub.sv
// ----------------------------------------------------------------------------
// mmio_button_hub: debounced sticky button flags and output register on dmem
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mmio_button_hub #(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BTN_BASE        = 3000,
  parameter int BTN_STRIDE      = 1000,
  parameter int STATUS_ADDR     = 1000,
  parameter int OUT_ADDR        = 2000,
  parameter int CLEAR_ON_READ   = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [31:0]        address_dmem,
  input  logic               wren,
  input  logic [31:0]        data,
  input  logic [31:0]        ram_q,
  output logic [31:0]        q_dmem,
  output logic [31:0]        out_data,
  output logic               out_valid,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               btn_pending
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] flag_q, flag_d;
  logic [CW-1:0]      cnt_q [NUM_BTN];
  logic [CW-1:0]      cnt_d [NUM_BTN];
  logic [31:0]        q_dmem_q, q_dmem_d;
  logic [31:0]        out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic [NUM_BTN-1:0] ch_hit, rise, clr;
  logic               status_hit, out_hit;

  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      ch_hit[i] = (address_dmem == 32'(BTN_BASE + i * BTN_STRIDE));
    end
    status_hit = (address_dmem == 32'(STATUS_ADDR));
    out_hit    = (address_dmem == 32'(OUT_ADDR));
  end

  // The toggle lands on the edge that would bring the count to DEBOUNCE_CYCLES.
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      level_d[i] = level_q[i];
      cnt_d[i]   = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = ~level_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rise = level_d & ~level_q;
    clr  = '0;
    if (wren && data[0]) begin
      clr = ch_hit;
    end else if (!wren && (CLEAR_ON_READ != 0)) begin
      clr = ch_hit;
    end
    // A press on the same edge as a clear must survive.
    flag_d = (flag_q & ~clr) | rise;
  end

  always_comb begin
    q_dmem_d    = q_dmem_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    if (wren) begin
      if (out_hit) begin
        out_data_d  = data;
        out_valid_d = 1'b1;
      end
    end else begin
      q_dmem_d = ram_q;
      if (status_hit) begin
        q_dmem_d              = '0;
        q_dmem_d[NUM_BTN-1:0] = level_q;
      end
      for (int i = 0; i < NUM_BTN; i++) begin
        if (ch_hit[i]) begin
          q_dmem_d = {31'b0, flag_q[i]};
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      flag_q      <= '0;
      q_dmem_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      flag_q      <= flag_d;
      q_dmem_q    <= q_dmem_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign q_dmem      = q_dmem_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign btn_level   = level_q;
  assign btn_pending = |flag_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_button_hub.sv
// ----------------------------------------------------------------------------
// tb_mmio_button_hub: scoreboard bench, clear-on-read and write-1-clear variants
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mmio_button_hub;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  btn_raw;
  logic [31:0] address_dmem, data, ram_q;
  logic        wren;

  logic [31:0] q_a, od_a, q_b, od_b;
  logic        ov_a, pend_a, ov_b, pend_b;
  logic [4:0]  lvl_a, lvl_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] ea;
    logic [31:0] eb;
  } exp_t;
  exp_t sbq[$];

  always #5 clock = ~clock;

  mmio_button_hub #(.CLEAR_ON_READ(1)) dut_a (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .address_dmem(address_dmem),
    .wren(wren), .data(data), .ram_q(ram_q), .q_dmem(q_a), .out_data(od_a),
    .out_valid(ov_a), .btn_level(lvl_a), .btn_pending(pend_a));

  mmio_button_hub #(.CLEAR_ON_READ(0)) dut_b (
    .clock(clock), .reset(reset), .btn_raw(btn_raw), .address_dmem(address_dmem),
    .wren(wren), .data(data), .ram_q(ram_q), .q_dmem(q_b), .out_data(od_b),
    .out_valid(ov_b), .btn_level(lvl_b), .btn_pending(pend_b));

  task automatic idle();
    address_dmem = 32'd0;
    wren         = 1'b0;
    data         = 32'd0;
    ram_q        = 32'd0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0; btn_raw = '0; idle();
    step(2);
    total++;
    if ({q_a, od_a, ov_a, lvl_a, pend_a} !== '0) begin
      bad++; $display("FAIL reset_state: q=%h out=%h v=%b lvl=%b pend=%b required all 0",
                      q_a, od_a, ov_a, lvl_a, pend_a);
    end
    reset = 1'b1;
    step(1);
    address_dmem = 32'd2000; wren = 1'b1; data = 32'hA5A5;
    @(negedge clock);
    total++;
    if (od_a !== 32'hA5A5 || ov_a !== 1'b1) begin
      bad++; $display("FAIL pre_reset_write: out=%h v=%b required A5A5 1", od_a, ov_a);
    end
    address_dmem = 32'd7; wren = 1'b0; ram_q = 32'h55; btn_raw[1] = 1'b1;
    step(12);
    total++;
    if (q_a !== 32'h55) begin
      bad++; $display("FAIL pre_reset_read: q=%h required 55", q_a);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({q_a, od_a, ov_a, lvl_a, pend_a} !== '0) begin
      bad++; $display("FAIL async_reset: q=%h out=%h v=%b lvl=%b pend=%b required all 0",
                      q_a, od_a, ov_a, lvl_a, pend_a);
    end
    @(negedge clock);
    idle(); reset = 1'b1;
    step(17);
    total++;
    if (lvl_a !== 5'b00000) begin
      bad++; $display("FAIL reset_lost_debounce: lvl=%b required 00000", lvl_a);
    end
    step(1);
    total++;
    if (lvl_a !== 5'b00010 || pend_a !== 1'b1) begin
      bad++; $display("FAIL full_debounce_after_reset: lvl=%b pend=%b required 00010 1", lvl_a, pend_a);
    end
    btn_raw = '0;
    step(20);
    total++;
    if (lvl_a !== 5'b00000 || pend_a !== 1'b1) begin
      bad++; $display("FAIL release_keeps_flag: lvl=%b pend=%b required 00000 1", lvl_a, pend_a);
    end
    address_dmem = 32'd4000; wren = 1'b1; data = 32'd1;
    @(negedge clock);
    idle();
    total++;
    if (pend_a !== 1'b0 || pend_b !== 1'b0) begin
      bad++; $display("FAIL write1_clear_ch1: pend_a=%b pend_b=%b required 0 0", pend_a, pend_b);
    end
  endtask

  task automatic test_debounce();
    idle();
    btn_raw[2] = 1'b1;
    step(15);
    btn_raw[2] = 1'b0;
    step(4);
    total++;
    if (lvl_a !== 5'b00000 || pend_a !== 1'b0) begin
      bad++; $display("FAIL glitch_15: lvl=%b pend=%b required 00000 0", lvl_a, pend_a);
    end
    step(4);
    btn_raw[2] = 1'b1;
    step(17);
    total++;
    if (lvl_a !== 5'b00000) begin
      bad++; $display("FAIL press_17: lvl=%b required 00000", lvl_a);
    end
    step(1);
    total++;
    if (lvl_a !== 5'b00100 || pend_a !== 1'b1 || pend_b !== 1'b1) begin
      bad++; $display("FAIL press_18: lvl=%b pend_a=%b pend_b=%b required 00100 1 1",
                      lvl_a, pend_a, pend_b);
    end
  endtask

  task automatic run_ops(input string tag, input int n, input logic [31:0] ad[8],
                         input bit we[8], input logic [31:0] dv[8], input logic [31:0] rq[8],
                         input logic [31:0] ea[8], input logic [31:0] eb[8]);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      address_dmem = ad[i]; wren = we[i]; data = dv[i]; ram_q = rq[i];
      sbq.push_back(exp_t'{name: $sformatf("%s_op%0d", tag, i), ea: ea[i], eb: eb[i]});
      @(negedge clock);
      e = sbq.pop_front();
      total++;
      if (q_a !== e.ea) begin
        bad++; $display("FAIL %s clear_on_read: q_dmem=%h required %h", e.name, q_a, e.ea);
      end
      total++;
      if (q_b !== e.eb) begin
        bad++; $display("FAIL %s write_clear: q_dmem=%h required %h", e.name, q_b, e.eb);
      end
    end
    idle();
  endtask

  task automatic test_flag_read();
    logic [31:0] ad[8] = '{32'd5000, 32'd5000, 32'd5000, 32'd5000, 0, 0, 0, 0};
    bit          we[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] dv[8] = '{32'd1, 32'd1, 32'd1, 32'd1, 0, 0, 0, 0};
    logic [31:0] rq[8] = '{32'h77, 32'h77, 32'h77, 32'h77, 0, 0, 0, 0};
    logic [31:0] ea[8] = '{32'd1, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0};
    logic [31:0] eb[8] = '{32'd1, 32'd1, 32'd1, 32'd0, 0, 0, 0, 0};
    run_ops("flag", 4, ad, we, dv, rq, ea, eb);
    total++;
    if (pend_a !== 1'b0 || pend_b !== 1'b0 || lvl_a !== 5'b00100) begin
      bad++; $display("FAIL flag_cleared: pend_a=%b pend_b=%b lvl=%b required 0 0 00100",
                      pend_a, pend_b, lvl_a);
    end
    btn_raw[2] = 1'b0;
    step(20);
  endtask

  task automatic test_race();
    logic [31:0] ad[8] = '{32'd3000, 32'd3000, 32'd3000, 32'd3000, 32'd3000, 0, 0, 0};
    bit          we[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] dv[8] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 0, 0, 0};
    logic [31:0] rq[8] = '{32'h99, 32'h99, 32'h99, 32'h99, 32'h99, 0, 0, 0};
    logic [31:0] ea[8] = '{32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 0, 0, 0};
    logic [31:0] eb[8] = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd0, 0, 0, 0};
    idle();
    btn_raw[0] = 1'b1;
    step(17);
    run_ops("race", 5, ad, we, dv, rq, ea, eb);
    total++;
    if (pend_a !== 1'b0 || pend_b !== 1'b0 || lvl_a !== 5'b00001) begin
      bad++; $display("FAIL race_end: pend_a=%b pend_b=%b lvl=%b required 0 0 00001",
                      pend_a, pend_b, lvl_a);
    end
    btn_raw[0] = 1'b0;
    step(20);
  endtask

  task automatic test_out();
    logic [31:0] ad[4]  = '{32'd7, 32'd2000, 32'd2000, 32'd2000};
    bit          we[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] dv[4]  = '{32'd0, 32'hDEADBEEF, 32'h0BADF00D, 32'd0};
    logic [31:0] rq[4]  = '{32'h1234, 32'h1111, 32'h2222, 32'hCAFE};
    logic [31:0] eq[4]  = '{32'h1234, 32'h1234, 32'h1234, 32'hCAFE};
    logic [31:0] eod[4] = '{32'd0, 32'hDEADBEEF, 32'h0BADF00D, 32'h0BADF00D};
    bit          eov[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      address_dmem = ad[i]; wren = we[i]; data = dv[i]; ram_q = rq[i];
      sbq.push_back(exp_t'{name: $sformatf("out_op%0d", i), ea: eq[i], eb: eod[i]});
      @(negedge clock);
      e = sbq.pop_front();
      total++;
      if (q_a !== e.ea) begin
        bad++; $display("FAIL %s q_dmem: got %h required %h", e.name, q_a, e.ea);
      end
      total++;
      if (od_a !== e.eb || ov_a !== eov[i]) begin
        bad++; $display("FAIL %s out: data=%h valid=%b required %h %b", e.name, od_a, ov_a, e.eb, eov[i]);
      end
    end
    idle();
  endtask

  task automatic test_status();
    logic [31:0] ad[8] = '{32'd1000, 32'd4000, 32'd7000, 32'd6000, 32'd4000, 32'd0, 0, 0};
    bit          we[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] dv[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] rq[8] = '{32'h5, 32'h5, 32'h5, 32'h5, 32'h5, 32'h9, 0, 0};
    logic [31:0] ea[8] = '{32'd18, 32'd1, 32'd1, 32'd0, 32'd0, 32'h9, 0, 0};
    logic [31:0] eb[8] = '{32'd18, 32'd1, 32'd1, 32'd0, 32'd1, 32'h9, 0, 0};
    idle();
    btn_raw = 5'b10010;
    step(18);
    run_ops("status", 6, ad, we, dv, rq, ea, eb);
    btn_raw = '0;
    step(20);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_debounce();
    test_flag_read();
    test_race();
    test_out();
    test_status();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
